// File: rtl/x_uart_pkg.sv
// x_uart_pkg: definitions shared by the UART receive and transmit halves.
//   uart_state_t          - frame phase, used by both the RX and the TX FSM
//   UART_CLKS_PER_BIT_DEF - default clocks per bit (12 MHz / 115200)
//   UART_DATA_BITS        - data bits per frame (8N1)
package x_uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

  localparam int UART_CLKS_PER_BIT_DEF = 104;
  localparam int UART_DATA_BITS        = 8;

endpackage

// File: rtl/x_uart_rx.sv
// x_uart_rx: 8N1 receiver with a two-flop input synchroniser.
// Ports:
//   i_clk, i_rst  - clock, asynchronous active-high reset
//   i_rx          - asynchronous serial input, idle high
//   o_rx_valid    - one-cycle pulse, byte received
//   o_rx_data     - received byte, held until the next good byte
//   o_rx_err      - one-cycle pulse, stop bit sampled low
// CLKS_PER_BIT must be >= 4.
module x_uart_rx
  import x_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic       o_rx_valid,
  output logic [7:0] o_rx_data,
  output logic       o_rx_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_BIT = 3'(UART_DATA_BITS - 1);

  logic        rx_meta_q, rx_s_q;
  uart_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = START;
      end
      START: begin
        // Re-check the line half a bit in; a high level here was a glitch.
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s_q ? IDLE : DATA;
        end
      end
      DATA: begin
        // Counting a full bit from the start-bit centre lands on each bit centre.
        if (cnt_q == CNT_FULL) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == LAST_BIT) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rx_s_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      // Synchroniser resets to the idle level so release is not seen as a start.
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      rx_meta_q <= i_rx;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  assign o_rx_valid = valid_q;
  assign o_rx_data  = data_q;
  assign o_rx_err   = err_q;

endmodule

// File: rtl/x_uart.sv
// x_uart: full-duplex 8N1 UART link; independent RX (x_uart_rx) and inline TX.
// Ports:
//   i_clk, i_rst            - clock, asynchronous active-high reset
//   i_rx                    - serial input, idle high
//   o_tx                    - serial output, idle high, driven from a flop
//   o_rx_valid/data/err     - received byte pulse, byte, framing-error pulse
//   i_tx_valid, i_tx_data   - byte offered for transmit
//   o_tx_ready              - transmitter idle; accept when valid & ready
// CLKS_PER_BIT must be >= 4.
module x_uart
  import x_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic       o_tx,
  output logic       o_rx_valid,
  output logic [7:0] o_rx_data,
  output logic       o_rx_err,
  input  logic       i_tx_valid,
  input  logic [7:0] i_tx_data,
  output logic       o_tx_ready
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_BIT = 3'(UART_DATA_BITS - 1);

  x_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_rx       (i_rx),
    .o_rx_valid (o_rx_valid),
    .o_rx_data  (o_rx_data),
    .o_rx_err   (o_rx_err)
  );

  uart_state_t   tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic          tx_q, tx_d;
  logic          tx_ready_q, tx_ready_d;

  // tx_d is the line level for the next cycle, so each phase change sets the
  // level of the phase being entered.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 1'b1;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    case (tx_state_q)
      IDLE: begin
        tx_cnt_d = '0;
        tx_d     = 1'b1;
        if (i_tx_valid && tx_ready_q) begin
          tx_shift_d = i_tx_data;
          tx_state_d = START;
          tx_d       = 1'b0;
        end
      end
      START: begin
        if (tx_cnt_q == CNT_FULL) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = DATA;
          tx_d       = tx_shift_q[0];
        end
      end
      DATA: begin
        if (tx_cnt_q == CNT_FULL) begin
          tx_cnt_d = '0;
          if (tx_bit_q == LAST_BIT) begin
            tx_state_d = STOP;
            tx_d       = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_d       = tx_shift_q[1];
          end
        end
      end
      STOP: begin
        if (tx_cnt_q == CNT_FULL) begin
          tx_cnt_d   = '0;
          tx_state_d = IDLE;
          tx_d       = 1'b1;
        end
      end
      default: begin
        tx_state_d = IDLE;
        tx_d       = 1'b1;
      end
    endcase
    tx_ready_d = (tx_state_d == IDLE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tx_state_q <= IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
      tx_ready_q <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
      tx_ready_q <= tx_ready_d;
    end
  end

  assign o_tx       = tx_q;
  assign o_tx_ready = tx_ready_q;

endmodule

// File: tb/tb_x_uart.sv
// tb_x_uart: directed plus randomized checks of x_uart with CLKS_PER_BIT = 8.
// The reference is the 8N1 frame itself: expected line levels are
// {stop=1, data LSB-first, start=0}; received bytes must equal sent bytes.
module tb_x_uart;

  localparam int CPB = 8;
  localparam int RX_LAT = (19 * CPB) / 2 + 3;  // 9.5 bit times + 3 clocks

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_drive = 1'b1;
  logic       loop_en = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       rx_line, tx_line, rx_valid, rx_err, tx_ready;
  logic [7:0] rx_data;

  assign rx_line = loop_en ? tx_line : rx_drive;

  always #5 clk = ~clk;

  x_uart #(.CLKS_PER_BIT(CPB)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_rx       (rx_line),
    .o_tx       (tx_line),
    .o_rx_valid (rx_valid),
    .o_rx_data  (rx_data),
    .o_rx_err   (rx_err),
    .i_tx_valid (tx_valid),
    .i_tx_data  (tx_data),
    .o_tx_ready (tx_ready)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int err_pulses = 0;
  logic [7:0] got_q[$];
  int         got_cyc_q[$];
  logic [7:0] last_good = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  // Receive monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rx_valid) begin
      got_q.push_back(rx_data);
      got_cyc_q.push_back(cyc);
    end
    if (rx_err) err_pulses <= err_pulses + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_rx_frame(input logic [7:0] b, input logic stop_bit, output int start_cyc);
    rx_drive  = 1'b0;
    start_cyc = cyc;
    step(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_drive = b[i];
      step(CPB);
    end
    rx_drive = stop_bit;
    step(CPB);
    rx_drive = 1'b1;
  endtask

  task automatic rx_frame_test(input string tag, input logic [7:0] b, input logic stop_bit);
    int s, n0, e0, lat;
    n0 = got_q.size();
    e0 = err_pulses;
    send_rx_frame(b, stop_bit, s);
    step(2 * CPB);
    if (stop_bit) begin
      check({tag, "_count"}, got_q.size() - n0, 1);
      check({tag, "_err"}, err_pulses - e0, 0);
      if (got_q.size() > n0) begin
        lat = got_cyc_q[n0] - s;
        check({tag, "_data"}, {24'h0, got_q[n0]}, {24'h0, b});
        check({tag, "_latency_ok"}, (lat >= RX_LAT && lat <= RX_LAT + 2) ? 1 : 0, 1);
      end
      last_good = b;
    end else begin
      check({tag, "_count"}, got_q.size() - n0, 0);
      check({tag, "_err"}, err_pulses - e0, 1);
      check({tag, "_held"}, {24'h0, rx_data}, {24'h0, last_good});
    end
  endtask

  // Transmit one byte with loopback off and compare every cycle of the line.
  task automatic tx_frame_test(input string tag, input logic [7:0] b);
    logic [9:0] f;
    int mism[10];
    int low_cnt;
    f = {1'b1, b, 1'b0};
    low_cnt = 0;
    for (int k = 0; k < 10; k++) mism[k] = 0;
    check({tag, "_ready_before"}, tx_ready, 1);
    tx_data  = b;
    tx_valid = 1'b1;
    step(1);
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
    for (int i = 0; i < 10 * CPB; i++) begin
      if (tx_line !== f[i / CPB]) mism[i / CPB]++;
      if (tx_ready === 1'b0) low_cnt++;
      step(1);
    end
    for (int k = 0; k < 10; k++) check($sformatf("%s_bit%0d", tag, k), mism[k], 0);
    check({tag, "_ready_low_cycles"}, low_cnt, 10 * CPB);
    check({tag, "_ready_after"}, tx_ready, 1);
  endtask

  task automatic wait_ready(input string tag, output int waited);
    waited = 0;
    while (tx_ready !== 1'b1 && waited < 20 * CPB) begin
      step(1);
      waited++;
    end
    check({tag, "_ready_timeout"}, tx_ready, 1);
  endtask

  initial begin
    int n0, e0, w;
    logic [7:0] b;

    // Reset state
    step(3);
    check("rst_tx", tx_line, 1);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_err", rx_err, 0);
    check("rst_tx_ready", tx_ready, 1);
    rst = 1'b0;
    step(4);
    check("post_rst_ready", tx_ready, 1);
    check("post_rst_tx", tx_line, 1);

    // Ideal frame
    rx_frame_test("rx_a5", 8'hA5, 1'b1);

    // Transmit 0x3C
    tx_frame_test("tx_3c", 8'h3C);

    // Glitch rejection, then a clean 0x00 frame
    n0 = got_q.size();
    e0 = err_pulses;
    rx_drive = 1'b0;
    step(3);
    rx_drive = 1'b1;
    step(3 * CPB);
    check("glitch_valid", got_q.size() - n0, 0);
    check("glitch_err", err_pulses - e0, 0);
    rx_frame_test("rx_00", 8'h00, 1'b1);

    // Framing error keeps the previous byte
    rx_frame_test("rx_55_ferr", 8'h55, 1'b0);

    // Randomized receive frames, some with a bad stop bit
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom_range(0, 255));
      rx_frame_test($sformatf("rx_rand%0d", i), b, ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
      step($urandom_range(1, 5));
    end

    // Randomized transmit frames
    for (int i = 0; i < 3; i++) begin
      tx_frame_test($sformatf("tx_rand%0d", i), 8'($urandom_range(0, 255)));
      step($urandom_range(1, 5));
    end

    // Loopback, back-to-back 0x01 then 0xFF
    loop_en = 1'b1;
    step(2);
    n0 = got_q.size();
    e0 = err_pulses;
    tx_data  = 8'h01;
    tx_valid = 1'b1;
    step(1);
    tx_data = 8'hFF;
    wait_ready("loop_first", w);
    check("loop_first_len", w, 10 * CPB);
    check("loop_gap_line", tx_line, 1);
    step(1);
    check("loop_gap_one_cycle", tx_ready, 0);
    tx_valid = 1'b0;
    wait_ready("loop_second", w);
    step(2 * CPB);
    check("loop_count", got_q.size() - n0, 2);
    check("loop_err", err_pulses - e0, 0);
    if (got_q.size() >= n0 + 2) begin
      check("loop_byte0", got_q[n0], 8'h01);
      check("loop_byte1", got_q[n0 + 1], 8'hFF);
    end

    // Reset during data bit 4, then a clean loopback frame
    tx_data  = 8'h0F;
    tx_valid = 1'b1;
    step(1);
    tx_valid = 1'b0;
    step(5 * CPB + 2);
    check("midrst_tx_before", tx_line, 0);
    rst = 1'b1;
    #1;
    check("midrst_tx_async", tx_line, 1);
    step(2);
    check("midrst_ready_in_rst", tx_ready, 1);
    rst = 1'b0;
    step(2);
    check("midrst_ready_after", tx_ready, 1);
    n0 = got_q.size();
    e0 = err_pulses;
    tx_data  = 8'h7E;
    tx_valid = 1'b1;
    step(1);
    tx_valid = 1'b0;
    wait_ready("midrst_7e", w);
    step(2 * CPB);
    check("midrst_count", got_q.size() - n0, 1);
    check("midrst_err", err_pulses - e0, 0);
    if (got_q.size() > n0) check("midrst_byte", got_q[n0], 8'h7E);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
